// File: rtl/run_ctrl_pkg.sv
// Shared types and default constants for the run_ctrl boot/run sequencer.
package run_ctrl_pkg;

  // Sequencer states: hold everything in reset, release channels one by one,
  // run under the watchdog, then park in one of two terminal states.
  typedef enum logic [2:0] {
    ST_HOLD    = 3'd0,
    ST_RELEASE = 3'd1,
    ST_RUN     = 3'd2,
    ST_DONE    = 3'd3,
    ST_TIMEOUT = 3'd4
  } state_e;

  localparam int DEF_N_CH        = 2;
  localparam int DEF_HOLD_CYCLES = 5;
  localparam int DEF_STAGGER     = 2;
  localparam int DEF_MAX_CYCLES  = 100;
  localparam int DEF_CNT_W       = 32;

  // Bits needed to hold values 0..max_val, never less than one bit.
  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage : run_ctrl_pkg

// File: rtl/run_ctrl.sv
// run_ctrl: holds N_CH core resets after reset release, releases them with a
// fixed stagger, then supervises the run with an optional watchdog. The run
// ends sticky in DONE (all cores halted) or TIMEOUT; sw_rst_req restarts it.
module run_ctrl
  import run_ctrl_pkg::*;
#(
  parameter int N_CH        = DEF_N_CH,
  parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
  parameter int STAGGER     = DEF_STAGGER,
  parameter int MAX_CYCLES  = DEF_MAX_CYCLES,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sw_rst_req,
  input  logic [N_CH-1:0]  halt_in,
  output logic [N_CH-1:0]  core_rst,
  output logic             running,
  output logic             done,
  output logic             timeout,
  output logic [CNT_W-1:0] cycle_cnt
);

  // Counter widths sized to the largest value each counter must reach.
  localparam int HOLD_W = cnt_width(HOLD_CYCLES - 1);
  localparam int STAG_W = cnt_width((STAGGER > 0) ? STAGGER - 1 : 0);
  localparam int IDX_W  = cnt_width(N_CH - 1);

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [STAG_W-1:0] STAG_LAST = STAG_W'((STAGGER > 0) ? STAGGER - 1 : 0);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(N_CH - 1);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'((MAX_CYCLES > 0) ? MAX_CYCLES - 1 : 0);

  // With one channel or no stagger every core leaves reset on the same edge.
  localparam bit DIRECT_RUN = (N_CH == 1) || (STAGGER == 0);
  localparam bit WDOG_EN    = (MAX_CYCLES != 0);

  state_e            state_q,     state_d;
  logic [HOLD_W-1:0] hold_cnt_q,  hold_cnt_d;
  logic [STAG_W-1:0] stag_cnt_q,  stag_cnt_d;
  logic [IDX_W-1:0]  ch_idx_q,    ch_idx_d;
  logic [N_CH-1:0]   core_rst_q,  core_rst_d;
  logic              running_q,   running_d;
  logic              done_q,      done_d;
  logic              timeout_q,   timeout_d;
  logic [CNT_W-1:0]  cycle_cnt_q, cycle_cnt_d;

  // Next-state and next-output logic for the whole sequencer.
  always_comb begin
    // NOTE: every _d signal gets its hold value first so no path through the
    // case statement leaves one unassigned, which would infer a latch.
    state_d     = state_q;
    hold_cnt_d  = hold_cnt_q;
    stag_cnt_d  = stag_cnt_q;
    ch_idx_d    = ch_idx_q;
    core_rst_d  = core_rst_q;
    running_d   = running_q;
    done_d      = done_q;
    timeout_d   = timeout_q;
    cycle_cnt_d = cycle_cnt_q;

    if (sw_rst_req) begin
      // Soft restart beats everything; holding it keeps the hold counter at 0.
      state_d     = ST_HOLD;
      hold_cnt_d  = '0;
      stag_cnt_d  = '0;
      ch_idx_d    = '0;
      core_rst_d  = '1;
      running_d   = 1'b0;
      done_d      = 1'b0;
      timeout_d   = 1'b0;
      cycle_cnt_d = '0;
    end else begin
      case (state_q)
        ST_HOLD: begin
          if (hold_cnt_q == HOLD_LAST) begin
            hold_cnt_d = '0;
            if (DIRECT_RUN) begin
              core_rst_d  = '0;
              running_d   = 1'b1;
              cycle_cnt_d = '0;
              state_d     = ST_RUN;
            end else begin
              core_rst_d[0] = 1'b0;
              stag_cnt_d    = '0;
              ch_idx_d      = IDX_W'(1);
              state_d       = ST_RELEASE;
            end
          end else begin
            hold_cnt_d = hold_cnt_q + 1'b1;
          end
        end

        ST_RELEASE: begin
          // halt_in is deliberately not looked at until the run starts.
          if (stag_cnt_q == STAG_LAST) begin
            stag_cnt_d = '0;
            for (int i = 0; i < N_CH; i++) begin
              if (ch_idx_q == IDX_W'(i)) core_rst_d[i] = 1'b0;
            end
            if (ch_idx_q == IDX_LAST) begin
              running_d   = 1'b1;
              cycle_cnt_d = '0;
              state_d     = ST_RUN;
            end else begin
              ch_idx_d = ch_idx_q + 1'b1;
            end
          end else begin
            stag_cnt_d = stag_cnt_q + 1'b1;
          end
        end

        ST_RUN: begin
          // Completion is checked first so it wins over a same-edge timeout.
          if (&halt_in) begin
            core_rst_d = '1;
            running_d  = 1'b0;
            done_d     = 1'b1;
            state_d    = ST_DONE;
          end else if (WDOG_EN && (cycle_cnt_q == CNT_LAST)) begin
            core_rst_d  = '1;
            running_d   = 1'b0;
            timeout_d   = 1'b1;
            cycle_cnt_d = cycle_cnt_q + 1'b1;
            state_d     = ST_TIMEOUT;
          end else if (cycle_cnt_q != '1) begin
            // Saturates at all-ones; only reachable with the watchdog off.
            cycle_cnt_d = cycle_cnt_q + 1'b1;
          end
        end

        ST_DONE, ST_TIMEOUT: begin
          // Terminal: everything holds until a restart.
        end

        default: begin
          // Unused encodings recover to a clean hold.
          state_d     = ST_HOLD;
          hold_cnt_d  = '0;
          stag_cnt_d  = '0;
          ch_idx_d    = '0;
          core_rst_d  = '1;
          running_d   = 1'b0;
          done_d      = 1'b0;
          timeout_d   = 1'b0;
          cycle_cnt_d = '0;
        end
      endcase
    end
  end

  // State, counters and registered outputs; rst forces the hold state at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_HOLD;
      hold_cnt_q  <= '0;
      stag_cnt_q  <= '0;
      ch_idx_q    <= '0;
      core_rst_q  <= '1;
      running_q   <= 1'b0;
      done_q      <= 1'b0;
      timeout_q   <= 1'b0;
      cycle_cnt_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q     <= state_d;
      hold_cnt_q  <= hold_cnt_d;
      stag_cnt_q  <= stag_cnt_d;
      ch_idx_q    <= ch_idx_d;
      core_rst_q  <= core_rst_d;
      running_q   <= running_d;
      done_q      <= done_d;
      timeout_q   <= timeout_d;
      cycle_cnt_q <= cycle_cnt_d;
    end
  end

  assign core_rst  = core_rst_q;
  assign running   = running_q;
  assign done      = done_q;
  assign timeout   = timeout_q;
  assign cycle_cnt = cycle_cnt_q;

endmodule : run_ctrl

// File: doc/run_ctrl.md
RUN_CTRL -- requirements
Module: run_ctrl

Interface
REQ-001 Parameter N_CH, default 2, number of independent core reset channels (>=1).
REQ-002 Parameter HOLD_CYCLES, default 5, cycles all channels stay in reset after rst release (>=1).
REQ-003 Parameter STAGGER, default 2, cycles between successive channel releases (0 = release all together).
REQ-004 Parameter MAX_CYCLES, default 100, watchdog run-length limit in cycles (0 = watchdog disabled).
REQ-005 Parameter CNT_W, default 32, width of the run cycle counter (2^CNT_W > MAX_CYCLES).
REQ-006 clk  input  1  single clock; all state updates on rising edge.
REQ-007 rst  input  1  reset, asynchronous, active-high.
REQ-008 sw_rst_req  input  1  synchronous soft restart request, sampled every edge.
REQ-009 halt_in  input  N_CH  per-channel "core halted" indication.
REQ-010 core_rst  output  N_CH  per-channel core reset, active-high.
REQ-011 running  output  1  high while in RUN.
REQ-012 done  output  1  sticky, all channels halted.
REQ-013 timeout  output  1  sticky, watchdog expired.
REQ-014 cycle_cnt  output  CNT_W  cycles elapsed in RUN.

Function
REQ-015 FSM states SHALL be HOLD, RELEASE, RUN, DONE, TIMEOUT; all outputs registered.
REQ-016 HOLD: internal counter counts edges; on the edge where it equals HOLD_CYCLES-1, go to RELEASE and clear core_rst[0] on that same edge.
REQ-017 core_rst[i] SHALL fall on the (HOLD_CYCLES + i*STAGGER)-th rising edge after rst deassertion; once cleared it stays low until DONE, TIMEOUT, sw_rst_req or rst.
REQ-018 On the edge that clears core_rst[N_CH-1], go to RUN; with N_CH=1 or STAGGER=0, HOLD goes directly to RUN, skipping RELEASE.
REQ-019 halt_in SHALL be ignored in HOLD and RELEASE.
REQ-020 RUN: running=1; cycle_cnt starts at 0 on entry and increments by 1 each edge spent in RUN.
REQ-021 RUN: if &halt_in is 1 at an edge, go to DONE; done=1, running=0, cycle_cnt frozen without incrementing.
REQ-022 RUN: if MAX_CYCLES!=0 and cycle_cnt==MAX_CYCLES-1 at an edge, go to TIMEOUT; timeout=1, running=0, cycle_cnt=MAX_CYCLES.
REQ-023 If the REQ-021 and REQ-022 conditions coincide, DONE wins; timeout stays 0.
REQ-024 DONE/TIMEOUT are terminal: all core_rst reassert to 1 on entry edge, outputs hold until sw_rst_req or rst.
REQ-025 sw_rst_req=1 at any edge, any state: next state HOLD; core_rst all 1, counters 0, running/done/timeout 0; overrides REQ-016 to REQ-024.
REQ-026 sw_rst_req held high keeps block in HOLD with hold counter at 0; sequence of REQ-016 starts from its falling edge.
REQ-027 cycle_cnt SHALL saturate at all-ones when the watchdog is disabled.

Reset
REQ-028 rst=1 SHALL immediately (asynchronously) force state HOLD, core_rst all 1, hold/stagger counters 0, cycle_cnt 0, running 0, done 0, timeout 0.
REQ-029 rst asserted mid-RELEASE or mid-RUN SHALL reassert every already-released core_rst without waiting for clk.
REQ-030 After rst falls, behaviour SHALL be identical to REQ-016 to REQ-018, regardless of pre-reset state.

Structure
REQ-031 State enum encoding and default parameter constants SHALL live in shared package run_ctrl_pkg.
REQ-032 No sub-module; a single FSM plus hold, stagger and cycle counters in run_ctrl.

Verification (N_CH=2, HOLD_CYCLES=5, STAGGER=2, MAX_CYCLES=100 unless stated)
REQ-033 rst high 5 cycles then low, halt_in=0 -> core_rst[0] falls edge 5, core_rst[1] falls edge 7, running=1 from edge 7.
REQ-034 halt_in=2'b11 asserted 10 cycles after RUN entry -> done=1, cycle_cnt=10, core_rst=2'b11, running=0, timeout=0.
REQ-035 halt_in held 0 -> timeout=1 at RUN edge 100, cycle_cnt=100, core_rst=2'b11; halt_in=2'b11 exactly at edge 100 -> done=1, timeout=0.
REQ-036 sw_rst_req pulsed in DONE, and again mid-RELEASE -> both cases: core_rst=2'b11, flags cleared, full REQ-033 sequence repeats.
REQ-037 rst asserted between clock edges during RUN -> core_rst=2'b11 and cycle_cnt=0 before next rising edge.
REQ-038 N_CH=4, STAGGER=0, MAX_CYCLES=0 -> all core_rst fall on edge 5; no timeout over 10000 cycles; cycle_cnt=10000.
